// File: rtl/ifu_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
// Used by instr_fetch_unit and ifu_stall_counter.
package ifu_pkg;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned LONG_OP_BIT = 7;
    localparam int unsigned STALL_W     = 16;

    typedef logic [2:0] ifu_state_t;

    localparam ifu_state_t IDLE  = 3'd0;
    localparam ifu_state_t REQ0  = 3'd1;
    localparam ifu_state_t WAIT0 = 3'd2;
    localparam ifu_state_t WAIT1 = 3'd3;
    localparam ifu_state_t OUT   = 3'd4;

endpackage

// File: rtl/ifu_stall_counter.sv
// Saturating count of cycles where the fetch unit holds an instruction the
// decoder has not yet taken. Only built when IFU_STALL_CNT_EN is defined.
module ifu_stall_counter
    import ifu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    output logic [STALL_W-1:0] count
);

    logic [STALL_W-1:0] count_q;
    logic [STALL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (stall && (count_q != {STALL_W{1'b1}})) begin
            count_d = count_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches 1- or 2-byte instructions from a byte memory and hands them to the
// decoder. Optional stall counter port enabled by defining IFU_STALL_CNT_EN.
module instr_fetch_unit
    import ifu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_step,
    output logic               pc_step_two,
    input  logic               flush,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_len2,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    ifu_state_t state_q;
    ifu_state_t state_d;
    logic [7:0] byte0_q;
    logic [7:0] byte1_q;
    logic       len2_q;
    logic       long_op;

    assign long_op = mem_rdata[LONG_OP_BIT];

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = REQ0;
        end else begin
            case (state_q)
                IDLE:    state_d = REQ0;
                REQ0:    state_d = WAIT0;
                WAIT0:   state_d = long_op ? WAIT1 : OUT;
                WAIT1:   state_d = OUT;
                OUT:     state_d = instr_ready ? REQ0 : OUT;
                default: state_d = IDLE;
            endcase
        end
    end

    // A flush drops whatever byte arrives this cycle; the held bytes are only
    // visible again once a fresh fetch reaches OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            byte0_q <= 8'h00;
            byte1_q <= 8'h00;
            len2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!flush) begin
                if (state_q == WAIT0) begin
                    byte0_q <= mem_rdata;
                    byte1_q <= 8'h00;
                    len2_q  <= long_op;
                end else if (state_q == WAIT1) begin
                    byte1_q <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        if (state_q == REQ0) begin
            mem_rd   = 1'b1;
            mem_addr = pc_in;
        end else if ((state_q == WAIT0) && long_op) begin
            mem_rd   = 1'b1;
            mem_addr = pc_in + ADDR_W'(1);
        end
    end

    assign instr_valid = (state_q == OUT);
    assign instr       = {byte0_q, byte1_q};
    assign instr_len2  = len2_q;
    assign pc_step     = instr_valid & instr_ready & ~flush;
    assign pc_step_two = pc_step & len2_q;

`ifdef IFU_STALL_CNT_EN
    logic stall;

    assign stall = instr_valid & ~instr_ready;

    ifu_stall_counter u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .count (stall_cnt)
    );
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have exactly these ports; width 1 where none is given:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- pc_in  in  8  current program-counter value
- pc_step  out  1  one-cycle pulse: advance PC
- pc_step_two  out  1  with pc_step: 1 = PC+2, 0 = PC+1
- flush  in  1  redirect by branch unit: abort current fetch
- mem_rd  out  1  byte-memory read strobe
- mem_addr  out  8  byte-memory address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
- instr  out  16  assembled instruction {byte0, byte1}, byte1 = 8'h00 for 1-byte instructions
- instr_len2  out  1  1 = 2-byte instruction
- instr_valid  out  1  instr is presented
- instr_ready  in  1  decoder accepts
- stall_cnt  out  16  present only with IFU_STALL_CNT_EN

Function
REQ-002 The FSM SHALL have exactly the states IDLE, REQ0, WAIT0, WAIT1 and OUT.
REQ-003 IDLE SHALL go to REQ0 on the next cycle unconditionally.
REQ-004 In REQ0 the block SHALL drive mem_rd=1 and mem_addr=pc_in, then enter WAIT0.
REQ-005 In WAIT0 the block SHALL register mem_rdata as byte0.
- If mem_rdata[7]=0: enter OUT.
- If mem_rdata[7]=1: drive mem_rd=1, mem_addr=pc_in+1 (8-bit, 8'hFF wraps to 8'h00), enter WAIT1.
REQ-006 In WAIT1 the block SHALL register mem_rdata as byte1 and enter OUT.
REQ-007 Latency from REQ0 entry to instr_valid=1 SHALL be 2 cycles for 1-byte instructions and 3 cycles for 2-byte instructions.
REQ-008 In OUT, instr_valid=1 and instr/instr_len2 SHALL stay stable until instr_valid & instr_ready.
REQ-009 On the handshake cycle the block SHALL pulse pc_step=1 with pc_step_two=instr_len2, then enter REQ0.
- REQ0 on the following cycle SHALL see the updated pc_in.
REQ-010 Outside the handshake cycle, pc_step and pc_step_two SHALL be 0.
REQ-011 mem_rd SHALL be 0 in every state and case not listed in REQ-004 and REQ-005.
REQ-012 flush=1 in any state SHALL:
- force the next state to REQ0;
- suppress pc_step in that cycle;
- discard any late mem_rdata.
REQ-013 flush and the handshake in the same cycle SHALL resolve as flush: no pc_step, instruction dropped.
REQ-014 instr_ready while instr_valid=0 SHALL have no effect.

Reset
REQ-015 reset SHALL take priority over flush and all other inputs.
REQ-016 On reset the block SHALL enter IDLE and drive instr_valid, pc_step, pc_step_two, mem_rd, instr_len2 = 0, instr = 16'h0000, mem_addr = 8'h00.
REQ-017 reset mid-fetch SHALL discard any outstanding memory response.

Configuration
REQ-018 With IFU_STALL_CNT_EN defined, stall_cnt SHALL:
- increment on every cycle with instr_valid=1 and instr_ready=0;
- saturate at 16'hFFFF;
- clear on reset;
- be unaffected by flush.
REQ-019 Without IFU_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 A shared package ifu_pkg SHALL hold the state enum, ADDR_W=8, INSTR_W=16 and LONG_OP_BIT=7.
REQ-021 The stall counter SHALL be a separate sub-module, ifu_stall_counter, instantiated only under IFU_STALL_CNT_EN.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- pc_in=8'h10, mem[10]=8'h05, instr_ready=1 -> instr=16'h0500, instr_len2=0, valid 2 cycles after REQ0; pc_step=1, pc_step_two=0.
- pc_in=8'h20, mem[20]=8'h9A, mem[21]=8'h3C -> mem_addr 8'h20 then 8'h21; instr=16'h9A3C, instr_len2=1, pc_step_two=1.
- pc_in=8'hFF, mem[FF]=8'h80, mem[00]=8'h11 -> second read at mem_addr=8'h00; instr=16'h8011.
- instr_ready held low 5 cycles in OUT -> instr stable, no pc_step, stall_cnt=5 (with macro); ready=1 -> single pc_step.
- flush in WAIT1, and flush coincident with the handshake -> no pc_step, REQ0 next cycle, new address fetched.
- reset asserted in WAIT0 -> next cycle in IDLE with all outputs at REQ-016 values; late mem_rdata ignored.
